bp_update_queue: RTL and testbench

BP_UPDATE_QUEUE -- requirements
Module: bp_update_queue

---
 rtl/bp_update_queue_pkg.sv | 31 +++
 rtl/bp_update_fifo.sv | 63 ++++++
 rtl/bp_update_queue.sv | 153 +++++++++++++++
 tb/tb_bp_update_queue.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_update_queue_pkg.sv
// ============================================================================
//  Module  : bp_update_queue_pkg (with minimal config_pkg core-configuration)
//  Brief   : Shared types and helpers for the branch-predictor update queue.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package config_pkg;
    typedef struct packed {
        int unsigned VLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32'd32};
endpackage

package bp_update_queue_pkg;
    // Widest PC the queue entry can carry; narrower cores zero-extend.
    localparam int unsigned c_max_vlen = 64;

    typedef struct packed {
        logic [c_max_vlen-1:0] pc;
        logic                  taken;
    } bp_entry_t;

    // Storage width of one entry: fixed header plus the caller's metadata.
    function automatic int unsigned entry_width(input int unsigned meta_w);
        return $bits(bp_entry_t) + meta_w;
    endfunction
endpackage

`default_nettype wire

// File: rtl/bp_update_fifo.sv
// ============================================================================
//  Module  : bp_update_fifo
//  Brief   : Circular storage and pointers for the predictor update queue.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_update_fifo
    import bp_update_queue_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_wdata,
    output logic [WIDTH-1:0]             o_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int unsigned c_ptr_w = $clog2(DEPTH);
    localparam int unsigned c_cnt_w = $clog2(DEPTH+1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    // Storage is left uninitialised; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/bp_update_queue.sv
// ============================================================================
//  Module  : bp_update_queue
//  Brief   : Holds predicted branches until resolution, then emits training
//            updates. Optional counters under BP_UPDATE_QUEUE_STATS_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_update_queue
    import bp_update_queue_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter type bp_metadata_t = logic,
    parameter type bht_update_t  = logic,
    parameter int unsigned DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          debug_mode_i,
    input  logic                          push_valid_i,
    output logic                          push_ready_o,
    input  logic [CVA6Cfg.VLEN-1:0]       push_pc_i,
    input  logic                          push_taken_i,
    input  bp_metadata_t                  push_meta_i,
    input  logic                          resolve_valid_i,
    input  logic                          resolve_taken_i,
    output bht_update_t                   bht_update_o,
    output logic                          mispredict_o,
    output logic                          underflow_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o
`ifdef BP_UPDATE_QUEUE_STATS_EN
    ,
    output logic [31:0]                   resolved_cnt_o,
    output logic [31:0]                   mispredict_cnt_o
`endif
);
    localparam int unsigned c_vlen    = CVA6Cfg.VLEN;
    localparam int unsigned c_meta_w  = $bits(bp_metadata_t);
    localparam int unsigned c_hdr_w   = $bits(bp_entry_t);
    localparam int unsigned c_entry_w = entry_width(c_meta_w);
    localparam int unsigned c_cnt_w   = $clog2(DEPTH+1);

    typedef struct packed {
        logic              valid;
        logic [c_vlen-1:0] pc;
        logic              taken;
        bp_metadata_t      metadata;
    } update_t;

    logic [c_cnt_w-1:0]   w_count;
    logic [c_entry_w-1:0] w_push_flat;
    logic [c_entry_w-1:0] w_head_flat;
    bp_entry_t            w_push_hdr;
    bp_entry_t            w_head_hdr;
    bp_metadata_t         w_head_meta;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_underflow;
    logic                 w_train;

    update_t              r_upd;
    logic                 r_mispredict;
    logic                 r_underflow;

    assign push_ready_o = (w_count < c_cnt_w'(DEPTH));
    assign count_o      = w_count;

    // Flush wins over both push and resolve in the same cycle.
    assign w_push      = push_valid_i && push_ready_o && !flush_i;
    assign w_pop       = resolve_valid_i && (w_count != '0) && !flush_i;
    assign w_underflow = resolve_valid_i && (w_count == '0) && !flush_i;
    assign w_train     = w_pop && !debug_mode_i;

    always_comb begin
        w_push_hdr       = '0;
        w_push_hdr.pc    = c_max_vlen'(push_pc_i);
        w_push_hdr.taken = push_taken_i;
    end

    assign w_push_flat = {push_meta_i, w_push_hdr};
    assign w_head_hdr  = bp_entry_t'(w_head_flat[c_hdr_w-1:0]);
    assign w_head_meta = bp_metadata_t'(w_head_flat[c_entry_w-1:c_hdr_w]);

    generate
        if (c_vlen < c_max_vlen) begin : g_pc_trim
            logic w_pc_hi_unused;
            assign w_pc_hi_unused = ^w_head_hdr.pc[c_max_vlen-1:c_vlen];
        end
    endgenerate

    bp_update_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_flush (flush_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_push_flat),
        .o_rdata (w_head_flat),
        .o_count (w_count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_upd        <= '0;
            r_mispredict <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_upd.valid <= w_train;
            if (w_pop) begin
                r_upd.pc       <= w_head_hdr.pc[c_vlen-1:0];
                r_upd.taken    <= resolve_taken_i;
                r_upd.metadata <= w_head_meta;
            end
            r_mispredict <= w_train && (w_head_hdr.taken ^ resolve_taken_i);
            r_underflow  <= w_underflow;
        end
    end

    // Field order of update_t matches the predictor's update struct.
    assign bht_update_o = bht_update_t'(r_upd);
    assign mispredict_o = r_mispredict;
    assign underflow_o  = r_underflow;

`ifdef BP_UPDATE_QUEUE_STATS_EN
    logic [31:0] r_resolved_cnt;
    logic [31:0] r_mispredict_cnt;

    // Statistics survive flushes; only reset clears them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_resolved_cnt   <= '0;
            r_mispredict_cnt <= '0;
        end else if (w_train) begin
            if (r_resolved_cnt != '1) begin
                r_resolved_cnt <= r_resolved_cnt + 32'd1;
            end
            if ((w_head_hdr.taken ^ resolve_taken_i) && (r_mispredict_cnt != '1)) begin
                r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
            end
        end
    end

    assign resolved_cnt_o   = r_resolved_cnt;
    assign mispredict_cnt_o = r_mispredict_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_update_queue.sv
// ============================================================================
//  Module  : tb_bp_update_queue
//  Brief   : Randomised bench for bp_update_queue against a queue model.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bp_update_queue;
    typedef logic [7:0] meta_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        taken;
        meta_t       metadata;
    } upd_t;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        meta_t       meta;
    } ent_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        debug_mode_i = 1'b0;
    logic        push_valid_i = 1'b0;
    logic        push_ready_o;
    logic [31:0] push_pc_i = '0;
    logic        push_taken_i = 1'b0;
    meta_t       push_meta_i = '0;
    logic        resolve_valid_i = 1'b0;
    logic        resolve_taken_i = 1'b0;
    upd_t        bht_update_o;
    logic        mispredict_o;
    logic        underflow_o;
    logic [3:0]  count_o;
`ifdef BP_UPDATE_QUEUE_STATS_EN
    logic [31:0] resolved_cnt_o;
    logic [31:0] mispredict_cnt_o;
`endif

    bp_update_queue #(
        .bp_metadata_t (meta_t),
        .bht_update_t  (upd_t),
        .DEPTH         (8)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .debug_mode_i    (debug_mode_i),
        .push_valid_i    (push_valid_i),
        .push_ready_o    (push_ready_o),
        .push_pc_i       (push_pc_i),
        .push_taken_i    (push_taken_i),
        .push_meta_i     (push_meta_i),
        .resolve_valid_i (resolve_valid_i),
        .resolve_taken_i (resolve_taken_i),
        .bht_update_o    (bht_update_o),
        .mispredict_o    (mispredict_o),
        .underflow_o     (underflow_o),
        .count_o         (count_o)
`ifdef BP_UPDATE_QUEUE_STATS_EN
        ,
        .resolved_cnt_o   (resolved_cnt_o),
        .mispredict_cnt_o (mispredict_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    ent_t        q[$];
    int unsigned exp_resolved = 0;
    int unsigned exp_mispred  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input logic r, input logic f, input logic d,
                        input logic pv, input logic [31:0] pc, input logic pt, input meta_t m,
                        input logic rv, input logic rt);
        ent_t h;
        int   sz;
        logic e_valid = 1'b0;
        logic e_mis   = 1'b0;
        logic e_uf    = 1'b0;
        logic [31:0] e_pc = '0;
        logic e_taken = 1'b0;
        meta_t e_meta = '0;

        rst_i = r; flush_i = f; debug_mode_i = d;
        push_valid_i = pv; push_pc_i = pc; push_taken_i = pt; push_meta_i = m;
        resolve_valid_i = rv; resolve_taken_i = rt;

        sz = q.size();
        if (r || f) begin
            q.delete();
            if (r) begin
                exp_resolved = 0;
                exp_mispred  = 0;
            end
        end else begin
            if (rv && sz > 0) begin
                h = q.pop_front();
                if (!d) begin
                    e_valid = 1'b1;
                    e_pc    = h.pc;
                    e_taken = rt;
                    e_meta  = h.meta;
                    e_mis   = h.taken ^ rt;
                    exp_resolved++;
                    if (e_mis) exp_mispred++;
                end
            end
            if (rv && sz == 0) e_uf = 1'b1;
            if (pv && sz < 8) q.push_back('{pc, pt, m});
        end

        @(posedge clk_i);
        @(negedge clk_i);

        check_eq("count", 64'(count_o), 64'(q.size()));
        check_eq("ready", 64'(push_ready_o), 64'(q.size() < 8));
        check_eq("upd_valid", 64'(bht_update_o.valid), 64'(e_valid));
        check_eq("mispredict", 64'(mispredict_o), 64'(e_mis));
        check_eq("underflow", 64'(underflow_o), 64'(e_uf));
        if (r) begin
            check_eq("reset_upd", 64'(bht_update_o), 64'd0);
        end
        if (e_valid) begin
            check_eq("upd_pc", 64'(bht_update_o.pc), 64'(e_pc));
            check_eq("upd_taken", 64'(bht_update_o.taken), 64'(e_taken));
            check_eq("upd_meta", 64'(bht_update_o.metadata), 64'(e_meta));
        end
`ifdef BP_UPDATE_QUEUE_STATS_EN
        check_eq("resolved_cnt", 64'(resolved_cnt_o), 64'(exp_resolved));
        check_eq("mispredict_cnt", 64'(mispredict_cnt_o), 64'(exp_mispred));
`endif
    endtask

    task automatic idle();
        step(0, 0, 0, 0, '0, 0, '0, 0, 0);
    endtask

    task automatic push(input logic [31:0] pc, input logic pt, input meta_t m);
        step(0, 0, 0, 1, pc, pt, m, 0, 0);
    endtask

    task automatic resolve(input logic rt, input logic d);
        step(0, 0, d, 0, '0, 0, '0, 1, rt);
    endtask

    initial begin
        int push_pct;
        int res_pct;

        step(1, 0, 0, 0, '0, 0, '0, 0, 0);
        idle();

        // Single branch predicted taken, resolved not taken.
        push(32'h1000, 1, 8'hA5);
        resolve(0, 0);
        idle();

        // Fill to capacity, overflow attempt, then drain in order.
        for (int i = 0; i < 9; i++) push(32'h2000 + 32'(i * 4), i[0], 8'(i));
        for (int i = 0; i < 8; i++) resolve(i[1], 0);

        // Resolve while empty.
        resolve(1, 0);
        idle();

        // Simultaneous push and pop at count 3.
        for (int i = 0; i < 3; i++) push(32'h3000 + 32'(i * 4), 1, 8'h30 + 8'(i));
        step(0, 0, 0, 1, 32'h3100, 0, 8'h77, 1, 1);
        for (int i = 0; i < 3; i++) resolve(0, 0);

        // Flush beats push and resolve at count 5.
        for (int i = 0; i < 5; i++) push(32'h4000 + 32'(i * 4), 0, 8'h40 + 8'(i));
        step(0, 1, 0, 1, 32'h4100, 1, 8'h99, 1, 1);
        idle();

        // Debug-mode resolve pops without training.
        push(32'h5000, 1, 8'h55);
        push(32'h5004, 0, 8'h56);
        resolve(0, 1);
        resolve(1, 0);

        // Mid-operation reset.
        push(32'h6000, 1, 8'h66);
        step(1, 0, 0, 1, 32'h6004, 1, 8'h67, 1, 0);
        idle();

        for (int i = 0; i < 3000; i++) begin
            push_pct = ((i / 300) % 2 == 0) ? 75 : 30;
            res_pct  = ((i / 300) % 2 == 0) ? 35 : 70;
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 79) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 99) < push_pct,
                 $urandom,
                 1'($urandom),
                 8'($urandom),
                 $urandom_range(0, 99) < res_pct,
                 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
